mcu_link_select: RTL and testbench

- Selects which MCU SPI link drives the core's MCU port: the on-board BL616 (internal) or an external M0S Dock.
- Synchronizes and filters both links.
- Commits to the external link only after confirmed complete frames, and switches only at a frame boundary with an enforced deselect gap.
- Optionally reverts to internal after a long external silence.
- MISO/INTn are fanned out to both MCUs outside this block and are not handled here.

---
 rtl/mcu_link_pkg.sv | 20 ++
 rtl/link_sync_filt.sv | 63 ++++++
 rtl/mcu_link_select.sv | 167 ++++++++++++++++
 tb/tb_mcu_link_select.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_link_pkg.sv
// Shared types and idle levels for the MCU SPI link selector.
package mcu_link_pkg;

  typedef enum logic [1:0] {
    INT   = 2'd0,
    PROBE = 2'd1,
    DRAIN = 2'd2,
    EXT   = 2'd3
  } state_e;

  typedef enum logic {
    LINK_INT = 1'b0,
    LINK_EXT = 1'b1
  } link_sel_t;

  localparam logic CSN_IDLE  = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/link_sync_filt.sv
// Synchronizes one SPI link and detects filtered csn low periods and complete frames.
module link_sync_filt
  import mcu_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic csn,
  input  logic mosi,
  output logic sclk_s,
  output logic csn_s,
  output logic mosi_s,
  output logic low_evt,
  output logic frame_done
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sclk_q, csn_q, mosi_q;
  logic [CW-1:0]          low_cnt_q, low_cnt_d;
  logic                   armed_q, armed_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= {SYNC_STAGES{SCLK_IDLE}};
      csn_q     <= {SYNC_STAGES{CSN_IDLE}};
      mosi_q    <= {SYNC_STAGES{MOSI_IDLE}};
      low_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      csn_q     <= {csn_q[SYNC_STAGES-2:0], csn};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
      low_cnt_q <= low_cnt_d;
      armed_q   <= armed_d;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign csn_s  = csn_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // low_cnt_q holds the number of earlier consecutive low cycles, so the
  // event fires on the FILT_LEN-th low cycle and never again in that period.
  assign low_evt = !csn_s && (low_cnt_q == CW'(FILT_LEN - 1));

  always_comb begin
    low_cnt_d = low_cnt_q;
    if (csn_s) begin
      low_cnt_d = '0;
    end else if (low_cnt_q < CW'(FILT_LEN)) begin
      low_cnt_d = low_cnt_q + CW'(1);
    end
  end

  // A rising edge only counts as a frame if a low event was seen first.
  assign armed_d    = csn_s ? 1'b0 : (armed_q | low_evt);
  assign frame_done = csn_s & armed_q;

endmodule

// File: rtl/mcu_link_select.sv
// Chooses the internal BL616 or external M0S SPI link for the core MCU port,
// switching only at frame boundaries with an enforced deselect gap.
module mcu_link_select
  import mcu_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILT_LEN       = 4,
  parameter int unsigned CONFIRM_FRAMES = 2,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic clk32,
  input  logic por,
  input  logic int_sclk,
  input  logic int_csn,
  input  logic int_mosi,
  input  logic ext_sclk,
  input  logic ext_csn,
  input  logic ext_mosi,
  output logic mcu_sclk,
  output logic mcu_csn,
  output logic mcu_mosi,
  output logic ext_active,
  output logic switch_evt
);

  localparam int unsigned SW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int unsigned FW = $clog2(CONFIRM_FRAMES + 1);

  logic int_sclk_s, int_csn_s, int_mosi_s, int_low_evt, unused_int_frame_done;
  logic ext_sclk_s, ext_csn_s, ext_mosi_s, ext_low_evt, ext_frame_done;

  state_e    state_q, state_d;
  link_sel_t target_q, target_d;
  logic [FW-1:0] frames_q, frames_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [SW-1:0] silence_q, silence_d;
  logic switch_evt_q;
  logic mcu_sclk_q, mcu_csn_q, mcu_mosi_q;
  logic fwd_sclk, fwd_csn, fwd_mosi;
  logic silence_sat, gap_done, tgt_csn;

  link_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_int (
    .clk       (clk32),
    .rst       (por),
    .sclk      (int_sclk),
    .csn       (int_csn),
    .mosi      (int_mosi),
    .sclk_s    (int_sclk_s),
    .csn_s     (int_csn_s),
    .mosi_s    (int_mosi_s),
    .low_evt   (int_low_evt),
    .frame_done(unused_int_frame_done)
  );

  link_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_ext (
    .clk       (clk32),
    .rst       (por),
    .sclk      (ext_sclk),
    .csn       (ext_csn),
    .mosi      (ext_mosi),
    .sclk_s    (ext_sclk_s),
    .csn_s     (ext_csn_s),
    .mosi_s    (ext_mosi_s),
    .low_evt   (ext_low_evt),
    .frame_done(ext_frame_done)
  );

  always_comb begin
    silence_d = silence_q;
    if (TIMEOUT_CYCLES == 0 || !ext_csn_s) begin
      silence_d = '0;
    end else if (silence_q != SW'(TIMEOUT_CYCLES)) begin
      silence_d = silence_q + SW'(1);
    end
  end

  assign silence_sat = (TIMEOUT_CYCLES != 0) && (silence_q == SW'(TIMEOUT_CYCLES));
  assign gap_done    = (int'(gap_q) + 1) >= int'(GAP_CYCLES);
  assign tgt_csn     = (target_q == LINK_EXT) ? ext_csn_s : int_csn_s;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    frames_d = '0;
    gap_d    = '0;
    unique case (state_q)
      INT: begin
        if (ext_low_evt) state_d = PROBE;
      end
      PROBE: begin
        frames_d = frames_q;
        // Once confirmed, hold off until the internal frame has finished.
        if (frames_q >= FW'(CONFIRM_FRAMES)) begin
          if (int_csn_s) begin
            state_d  = DRAIN;
            target_d = LINK_EXT;
          end
        end else if (ext_frame_done) begin
          frames_d = frames_q + FW'(1);
        end else if (silence_sat) begin
          state_d = INT;
        end
      end
      DRAIN: begin
        gap_d = gap_done ? gap_q : gap_q + GW'(1);
        if (gap_done && tgt_csn) begin
          state_d = (target_q == LINK_EXT) ? EXT : INT;
        end
      end
      EXT: begin
        if (silence_sat && int_low_evt) begin
          state_d  = DRAIN;
          target_d = LINK_INT;
        end
      end
    endcase
  end

  // Selection follows the current state, so the exit cycle of DRAIN still loads idle.
  always_comb begin
    fwd_sclk = int_sclk_s;
    fwd_csn  = int_csn_s;
    fwd_mosi = int_mosi_s;
    if (state_q == DRAIN) begin
      fwd_sclk = SCLK_IDLE;
      fwd_csn  = CSN_IDLE;
      fwd_mosi = MOSI_IDLE;
    end else if (state_q == EXT) begin
      fwd_sclk = ext_sclk_s;
      fwd_csn  = ext_csn_s;
      fwd_mosi = ext_mosi_s;
    end
  end

  always_ff @(posedge clk32) begin
    if (por) begin
      state_q      <= INT;
      target_q     <= LINK_INT;
      frames_q     <= '0;
      gap_q        <= '0;
      silence_q    <= '0;
      switch_evt_q <= 1'b0;
      mcu_sclk_q   <= SCLK_IDLE;
      mcu_csn_q    <= CSN_IDLE;
      mcu_mosi_q   <= MOSI_IDLE;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      frames_q     <= frames_d;
      gap_q        <= gap_d;
      silence_q    <= silence_d;
      switch_evt_q <= (state_q == DRAIN) && (state_d != DRAIN);
      mcu_sclk_q   <= fwd_sclk;
      mcu_csn_q    <= fwd_csn;
      mcu_mosi_q   <= fwd_mosi;
    end
  end

  assign mcu_sclk   = mcu_sclk_q;
  assign mcu_csn    = mcu_csn_q;
  assign mcu_mosi   = mcu_mosi_q;
  assign ext_active = (state_q == EXT);
  assign switch_evt = switch_evt_q;

endmodule

// File: tb/tb_mcu_link_select.sv
// Directed bench for mcu_link_select: switch events go through a scoreboard queue,
// forwarding is compared against a 3-cycle-delayed copy of the selected link.
module tb_mcu_link_select;
  import mcu_link_pkg::*;

  localparam int unsigned TO = 1000;

  logic clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic por;
  logic int_sclk, int_csn, int_mosi, ext_sclk, ext_csn, ext_mosi;
  logic mcu_sclk, mcu_csn, mcu_mosi, ext_active, switch_evt;
  logic z_sclk, z_csn, z_mosi, z_ext_active, z_switch_evt;

  mcu_link_select #(.TIMEOUT_CYCLES(TO)) dut (
    .clk32(clk32), .por(por),
    .int_sclk(int_sclk), .int_csn(int_csn), .int_mosi(int_mosi),
    .ext_sclk(ext_sclk), .ext_csn(ext_csn), .ext_mosi(ext_mosi),
    .mcu_sclk(mcu_sclk), .mcu_csn(mcu_csn), .mcu_mosi(mcu_mosi),
    .ext_active(ext_active), .switch_evt(switch_evt)
  );

  mcu_link_select #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk32(clk32), .por(por),
    .int_sclk(int_sclk), .int_csn(int_csn), .int_mosi(int_mosi),
    .ext_sclk(ext_sclk), .ext_csn(ext_csn), .ext_mosi(ext_mosi),
    .mcu_sclk(z_sclk), .mcu_csn(z_csn), .mcu_mosi(z_mosi),
    .ext_active(z_ext_active), .switch_evt(z_switch_evt)
  );

  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  logic fwd_chk = 1'b0;
  logic fwd_ext = 1'b0;
  logic nontrunc_chk = 1'b0;
  logic [2:0] hint[4];
  logic [2:0] hext[4];
  logic [2:0] want;
  logic prev_sw = 1'b0;
  logic e;
  int high_run = 0;
  state_e prev_state = INT;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      hint[i] = 3'b011;
      hext[i] = 3'b011;
    end
  end

  // Input history as sampled on each rising edge; index 2 is what the outputs show.
  always @(posedge clk32) begin
    for (int i = 3; i > 0; i--) begin
      hint[i] <= hint[i-1];
      hext[i] <= hext[i-1];
    end
    hint[0] <= {int_sclk, int_csn, int_mosi};
    hext[0] <= {ext_sclk, ext_csn, ext_mosi};
  end

  // Monitor
  always @(negedge clk32) begin
    want = fwd_ext ? hext[2] : hint[2];
    if (fwd_chk) check("fwd", {29'd0, mcu_sclk, mcu_csn, mcu_mosi}, {29'd0, want});
    if (switch_evt) begin
      if (exp_q.size() == 0) begin
        check("unexpected_switch", switch_evt, 0);
      end else begin
        e = exp_q.pop_front();
        check("switch_ext_active", ext_active, e);
        check("switch_single", prev_sw, 0);
        check("gap_held", (mcu_csn && high_run >= 4) ? 1 : 0, 1);
      end
    end
    if (nontrunc_chk && dut.state_q == DRAIN && prev_state == PROBE) begin
      check("drain_after_int_rise", hint[2][1], 1);
      check("int_low_before_drain", hint[3][1], 0);
    end
    high_run = mcu_csn ? high_run + 1 : 0;
    prev_sw = switch_evt;
    prev_state = dut.state_q;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic drive(input bit ext, input logic s, input logic c, input logic m);
    if (ext) begin
      ext_sclk = s; ext_csn = c; ext_mosi = m;
    end else begin
      int_sclk = s; int_csn = c; int_mosi = m;
    end
  endtask

  task automatic frame(input bit ext, input int bits, input logic [15:0] pat);
    drive(ext, 1'b0, 1'b0, 1'b1);
    step(2);
    for (int i = 0; i < bits; i++) begin
      drive(ext, 1'b0, 1'b0, pat[i%16]);
      step(1);
      drive(ext, 1'b1, 1'b0, pat[i%16]);
      step(1);
    end
    drive(ext, 1'b0, 1'b0, 1'b1);
    step(2);
    drive(ext, 1'b0, 1'b1, 1'b1);
    step(2);
  endtask

  task automatic wait_sb(input int max_cyc, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk32);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    // Reset with non-idle inputs: synchronizers and outputs must still read idle.
    por = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0);
    step(3);
    @(negedge clk32);
    check("rst_state", dut.state_q == INT, 1);
    check("rst_mcu", {29'd0, mcu_sclk, mcu_csn, mcu_mosi}, 32'b011);
    check("rst_ext_active", ext_active, 0);
    check("rst_switch_evt", switch_evt, 0);
    check("rst_counters", {dut.frames_q, dut.gap_q, dut.silence_q}, 0);
    drive(0, 1'b0, 1'b1, 1'b1);
    drive(1, 1'b0, 1'b1, 1'b1);
    step(2);
    por = 1'b0;
    step(4);
    fwd_chk = 1'b1;

    // Internal traffic only
    frame(0, 16, 16'hA5C3);
    step(3);
    frame(0, 16, 16'h0F0F);
    step(3);
    frame(0, 16, 16'hFFFF);
    step(3);
    check("int_only_ext_active", ext_active, 0);
    check("int_only_state", dut.state_q == INT, 1);

    // Ext csn glitch shorter than the filter
    drive(1, 1'b0, 1'b0, 1'b1);
    step(2);
    drive(1, 1'b0, 1'b1, 1'b1);
    step(6);
    check("glitch_state", dut.state_q == INT, 1);
    check("glitch_frames", dut.frames_q, 0);

    // Two ext frames with int idle -> switch to EXT
    exp_q.push_back(1'b1);
    frame(1, 16, 16'h1234);
    step(4);
    frame(1, 16, 16'hBEEF);
    wait_sb(40, "switch_to_ext");
    check("ext_active_on", ext_active, 1);
    check("dut0_ext_active_on", z_ext_active, 1);
    step(2);
    fwd_ext = 1'b1;
    frame(1, 16, 16'h3C5A);
    step(4);

    // Silence timeout then int low event -> back to INT; TIMEOUT=0 instance stays EXT
    step(TO + 20);
    exp_q.push_back(1'b0);
    frame(0, 16, 16'h5555);
    wait_sb(100, "revert_to_int");
    check("ext_active_off", ext_active, 0);
    check("dut0_sticky_ext", z_ext_active, 1);
    step(2);
    fwd_ext = 1'b0;
    frame(0, 16, 16'hC0DE);
    step(4);

    // Confirm reached mid internal frame: int frame must finish before DRAIN
    nontrunc_chk = 1'b1;
    exp_q.push_back(1'b1);
    fork
      frame(0, 100, 16'h9A6B);
      begin
        step(10);
        frame(1, 16, 16'h0001);
        step(4);
        frame(1, 16, 16'h8000);
      end
    join
    wait_sb(60, "switch_after_int_frame");
    nontrunc_chk = 1'b0;
    check("ext_active_nontrunc", ext_active, 1);

    // por in the middle of DRAIN
    fwd_chk = 1'b0;
    step(TO + 20);
    fork
      frame(0, 100, 16'h7E81);
      begin
        int n = 0;
        while (dut.state_q != DRAIN && n < 100) begin
          @(negedge clk32);
          n++;
        end
        check("drain_reached", dut.state_q == DRAIN, 1);
        por = 1'b1;
        @(posedge clk32);
        #1;
        por = 1'b0;
        @(negedge clk32);
        check("por_drain_state", dut.state_q == INT, 1);
        check("por_drain_mcu", {29'd0, mcu_sclk, mcu_csn, mcu_mosi}, 32'b011);
        check("por_drain_switch_evt", switch_evt, 0);
        check("por_drain_ext_active", ext_active, 0);
        check("por_drain_counters", {dut.frames_q, dut.gap_q, dut.silence_q}, 0);
      end
    join
    step(10);
    check("post_por_state", dut.state_q == INT, 1);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
